// File: rtl/timer_irq_ctrl.sv
// Interrupt acceptance for the 8-bit timer pair: edge-captured pending flags, mask, arbitration, irq/ack handshake.
// Optional feature: define TIMER_IRQ_ROTATE_EN for rotating priority (default build uses fixed priority).
module timer_irq_ctrl #(
    parameter int                   BIT_WIDTH = 8,
    parameter logic [BIT_WIDTH-1:0] VEC_BASE  = 8'h40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 CMIA0,
    input  logic                 CMIB0,
    input  logic                 OVI0,
    input  logic                 CMIA1,
    input  logic                 CMIB1,
    input  logic                 OVI1,
    input  logic [5:0]           irq_mask,
    input  logic                 irq_ack,
    output logic                 irq,
    output logic [BIT_WIDTH-1:0] irq_vector,
    output logic [5:0]           pending
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]           r_state;
    logic [5:0]           r_srcQ;
    logic [5:0]           r_pending;
    logic [2:0]           r_grant;
    logic [BIT_WIDTH-1:0] r_vector;

    logic [5:0] w_src;
    logic [5:0] w_rise;
    logic [5:0] w_clr;
    logic [5:0] w_elig;
    logic [2:0] w_base;
    logic [3:0] w_sum;
    logic       w_found;
    logic [2:0] w_pick;

    assign w_src  = {OVI1, CMIB1, CMIA1, OVI0, CMIB0, CMIA0};
    assign w_rise = w_src & ~r_srcQ;
    assign w_clr  = (r_state == REQ && irq_ack) ? (6'b000001 << r_grant) : 6'b000000;
    assign w_elig = r_pending & ~irq_mask;

`ifdef TIMER_IRQ_ROTATE_EN
    logic [2:0] r_ptr;

    assign w_base = r_ptr;

    // Priority restarts just after the most recently acknowledged source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 3'd0;
        end else if (r_state == REQ && irq_ack) begin
            r_ptr <= (r_grant == 3'd5) ? 3'd0 : r_grant + 3'd1;
        end
    end
`else
    assign w_base = 3'd0;
`endif

    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        w_sum   = 4'd0;
        for (int k = 0; k < 6; k++) begin
            w_sum = {1'b0, w_base} + 4'(k);
            if (w_sum >= 4'd6) begin
                w_sum = w_sum - 4'd6;
            end
            if (!w_found && w_elig[w_sum[2:0]]) begin
                w_found = 1'b1;
                w_pick  = w_sum[2:0];
            end
        end
    end

    // A fresh rising edge wins over the acknowledge clear so no event is lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_srcQ    <= 6'b0;
            r_pending <= 6'b0;
        end else begin
            r_srcQ    <= w_src;
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_grant  <= 3'd0;
            r_vector <= VEC_BASE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant  <= w_pick;
                        r_vector <= VEC_BASE + BIT_WIDTH'(w_pick);
                        r_state  <= REQ;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!irq_ack) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign irq        = (r_state == REQ);
    assign irq_vector = r_vector;
    assign pending    = r_pending;

endmodule
